// File: rtl/mix_columns_engine.sv
// Multi-lane AES MixColumns engine: LANES columns per cycle over valid/ready in and out.
// Define MIX_COLUMNS_INV_EN to compile in the InvMixColumns datapath selected by in_inv.
module mix_columns_engine #(
   parameter int LANES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // in_ready is high only in IDLE, out_valid only in DONE.
   if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("mix_columns_engine: LANES must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    col_idx;
   logic [127:0]  st_q;
   logic [127:0]  st_nxt;
   logic          last_cols;
   logic [31:0]   col_q   [4];
   logic [31:0]   col_d   [4];
   logic [1:0]    lane_idx [LANES];
   logic [31:0]   lane_res [LANES];

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_fwd(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] b [4];
      for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
      for (int r = 0; r < 4; r++)
         b[r] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      return {b[0], b[1], b[2], b[3]};
   endfunction

`ifdef MIX_COLUMNS_INV_EN
   logic mode_q;

   // 9, b, d and e multiples all derive from one x2/x4/x8 xtime chain per byte.
   function automatic logic [31:0] mix_inv(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] x2, x4, x8;
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] b [4];
      for (int r = 0; r < 4; r++) begin
         a[r]  = col[31-8*r -: 8];
         x2    = xtime(a[r]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[r] = x8 ^ a[r];
         mb[r] = x8 ^ x2 ^ a[r];
         md[r] = x8 ^ x4 ^ a[r];
         me[r] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++)
         b[r] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      return {b[0], b[1], b[2], b[3]};
   endfunction
`else
   logic unused_inv;
   assign unused_inv = in_inv;
`endif

   for (genvar c = 0; c < 4; c++) begin : g_col
      assign col_q[c]                = st_q[127-32*c -: 32];
      assign st_nxt[127-32*c -: 32]  = col_d[c];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = col_idx + 2'(l);
`ifdef MIX_COLUMNS_INV_EN
      assign lane_res[l] = mode_q ? mix_inv(col_q[lane_idx[l]]) : mix_fwd(col_q[lane_idx[l]]);
`else
      assign lane_res[l] = mix_fwd(col_q[lane_idx[l]]);
`endif
   end

   always_comb begin
      col_d = col_q;
      for (int l = 0; l < LANES; l++) col_d[lane_idx[l]] = lane_res[l];
   end

   // The pass that writes column 3 is the final one.
   assign last_cols = (({1'b0, col_idx} + 3'(LANES)) == 3'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = BUSY;
         BUSY:    if (last_cols) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == BUSY) || (state_q == DONE);
   end

   assign out_state = st_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= '0;
         col_idx <= '0;
`ifdef MIX_COLUMNS_INV_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               st_q    <= in_state;
               col_idx <= '0;
`ifdef MIX_COLUMNS_INV_EN
               mode_q  <= in_inv;
`endif
            end
            BUSY: begin
               st_q    <= st_nxt;
               col_idx <= col_idx + 2'(LANES);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Sequential, parametrised MixColumns / InvMixColumns engine for the AES SIMD datapath. It accepts a full 128-bit AES state over a valid/ready handshake and transforms `LANES` columns per clock using GF(2^8) arithmetic with reduction polynomial 0x11B. It presents the result on a second valid/ready handshake. It sits between the ShiftRows and AddRoundKey stages of the round pipeline and generalises the single-byte combinational column multiplier to whole-state, multi-lane, dual-mode operation.

## Interface
Parameters:
- `LANES`, default 1: columns processed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: an input state is offered.
- `in_ready`, output, 1: the engine can accept a state; high only in IDLE.
- `in_state`, input, 128: input state. Byte k = `in_state[127-8k -: 8]`, k = 0..15. Column c = bytes 4c..4c+3, row r = byte 4c+r (FIPS-197 order).
- `in_inv`, input, 1: 0 selects MixColumns, 1 selects InvMixColumns. Sampled on acceptance.
- `out_valid`, output, 1: the result is available.
- `out_ready`, input, 1: the consumer takes the result.
- `out_state`, output, 128: result, in the same byte order as `in_state`.
- `busy`, output, 1: high in BUSY or DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when `in_valid && in_ready`. On that edge, latch `in_state` into the state register, latch `in_inv` into the mode register, and clear `col_idx` to 0.
  - BUSY: each cycle, replace columns `col_idx .. col_idx+LANES-1` in the state register with their transformed values, then advance `col_idx` by `LANES`. When the columns just written include column 3, go to DONE.
  - DONE -> IDLE when `out_ready`. If `out_ready` is low, hold the state and `out_state` indefinitely.
- Per-column transform, for column bytes a0..a3:
  - Forward: b_r = 2·a_r ⊕ 3·a_(r+1) ⊕ a_(r+2) ⊕ a_(r+3), with indices mod 4.
  - Inverse: b_r = 0e·a_r ⊕ 0b·a_(r+1) ⊕ 0d·a_(r+2) ⊕ 09·a_(r+3).
- xtime(x) = (x<<1) ⊕ (x[7] ? 0x1B : 0x00), truncated to 8 bits. Constants 9, b, d and e are built from xtime chains; all arithmetic is 8-bit XOR with no carries.
- `out_state` is driven by the state register. It is only meaningful while `out_valid` is high.
- A new input is never accepted while busy. `in_valid` is ignored outside IDLE.
- Simultaneous `in_valid` with `out_ready` in DONE: the engine returns to IDLE first, so the new input is accepted on the following cycle.

## Timing
- Reset values, asynchronous on `rst_n` low: FSM = IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out_state` = 0, `col_idx` = 0, mode register = 0.
- Reset asserted mid-operation aborts the transform. The partially updated state is discarded, and no `out_valid` pulse follows.
- Latency: if a state is accepted at edge E0, `out_valid` rises after edge E0 + 4/LANES. That is 4 cycles for LANES=1, 2 cycles for LANES=2 and 1 cycle for LANES=4.
- `in_ready` rises again one cycle after the `out_valid && out_ready` handshake.
- Throughput: one state per 4/LANES + 2 cycles when the consumer always has `out_ready` high.
- `out_valid` deasserts on the edge following `out_valid && out_ready`.

## Configuration
- `MIX_COLUMNS_INV_EN` defined: inverse datapath compiled in, and `in_inv` selects the mode as specified above.
- `MIX_COLUMNS_INV_EN` undefined: only the forward datapath exists. `in_inv` is ignored and the mode register is tied to 0, so every state receives forward MixColumns. Latency and handshake are unchanged.

## Test plan
- Forward, LANES=1: `in_state` = db135345_f20a225c_01010101_c6c6c6c6, `in_inv`=0 -> after 4 cycles `out_state` = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, `out_valid`=1.
- Forward, LANES=2 and LANES=4: `in_state` = d4d4d4d5_2d26314c_db135345_f20a225c -> `out_state` = d5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d, with `out_valid` rising after 2 cycles and 1 cycle respectively.
- Inverse, with `MIX_COLUMNS_INV_EN` defined: `in_state` = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, `in_inv`=1 -> `out_state` = db135345_f20a225c_01010101_c6c6c6c6. The same stimulus with the macro undefined -> forward result 8e4da1bc... is not produced; the output is the forward MixColumns of the input.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `out_valid` and `out_state` stay stable and `in_ready` stays 0. Pulse `in_valid` during this time -> the pulse is ignored.
- Reset mid-operation, LANES=1: assert `rst_n`=0 two cycles after acceptance -> all outputs immediately return to their reset values. After release, the next accepted state produces a correct result.
- Back-to-back operation: send 3 states with `out_ready` held at 1 -> 3 correct results, each `in_ready` rising one cycle after the corresponding output handshake.
